// File: rtl/sine_pkg.sv
// Shared constants and state type for the sine voice scheduler and its sine table.
package sine_pkg;

  localparam int NUM_VOICES   = 4;
  localparam int PHASE_W      = 24;
  localparam int VIDX_W       = 2;
  localparam int TABLE_ADDR_W = 8;
  localparam int TABLE_DATA_W = 10;
  localparam int TABLE_MID    = 512;
  localparam int MIX_W        = 12;
  localparam int MIX_MID      = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sine_rom.sv
// Combinational 256-entry sine table, unsigned around TABLE_MID, built from a quarter wave.
module sine_rom
  import sine_pkg::*;
(
  input  logic [TABLE_ADDR_W-1:0] addr,
  output logic [TABLE_DATA_W-1:0] data
);

  // round(511 * sin(k * pi / 128)) for k = 0..64
  function automatic logic [8:0] quarter(input logic [6:0] k);
    logic [8:0] q;
    case (k)
      7'd0:  q = 9'd0;   7'd1:  q = 9'd13;  7'd2:  q = 9'd25;  7'd3:  q = 9'd38;
      7'd4:  q = 9'd50;  7'd5:  q = 9'd63;  7'd6:  q = 9'd75;  7'd7:  q = 9'd87;
      7'd8:  q = 9'd100; 7'd9:  q = 9'd112; 7'd10: q = 9'd124; 7'd11: q = 9'd136;
      7'd12: q = 9'd148; 7'd13: q = 9'd160; 7'd14: q = 9'd172; 7'd15: q = 9'd184;
      7'd16: q = 9'd196; 7'd17: q = 9'd207; 7'd18: q = 9'd218; 7'd19: q = 9'd230;
      7'd20: q = 9'd241; 7'd21: q = 9'd252; 7'd22: q = 9'd263; 7'd23: q = 9'd273;
      7'd24: q = 9'd284; 7'd25: q = 9'd294; 7'd26: q = 9'd304; 7'd27: q = 9'd314;
      7'd28: q = 9'd324; 7'd29: q = 9'd334; 7'd30: q = 9'd343; 7'd31: q = 9'd352;
      7'd32: q = 9'd361; 7'd33: q = 9'd370; 7'd34: q = 9'd379; 7'd35: q = 9'd387;
      7'd36: q = 9'd395; 7'd37: q = 9'd403; 7'd38: q = 9'd410; 7'd39: q = 9'd418;
      7'd40: q = 9'd425; 7'd41: q = 9'd432; 7'd42: q = 9'd438; 7'd43: q = 9'd445;
      7'd44: q = 9'd451; 7'd45: q = 9'd456; 7'd46: q = 9'd462; 7'd47: q = 9'd467;
      7'd48: q = 9'd472; 7'd49: q = 9'd477; 7'd50: q = 9'd481; 7'd51: q = 9'd485;
      7'd52: q = 9'd489; 7'd53: q = 9'd492; 7'd54: q = 9'd496; 7'd55: q = 9'd499;
      7'd56: q = 9'd501; 7'd57: q = 9'd503; 7'd58: q = 9'd505; 7'd59: q = 9'd507;
      7'd60: q = 9'd509; 7'd61: q = 9'd510; 7'd62: q = 9'd510; 7'd63: q = 9'd511;
      default: q = 9'd511;
    endcase
    return q;
  endfunction

  logic [6:0] k;
  logic [8:0] mag;

  always_comb begin
    k    = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    mag  = quarter(k);
    data = addr[7] ? (TABLE_DATA_W'(TABLE_MID) - {1'b0, mag})
                   : (TABLE_DATA_W'(TABLE_MID) + {1'b0, mag});
  end

endmodule

// File: rtl/sine_voice_sched.sv
// Time-multiplexes NUM_VOICES phase accumulators over one sine table, one voice per cycle,
// and emits one mixed 12-bit sample per accepted sample_tick.
module sine_voice_sched #(
  parameter int NUM_VOICES = sine_pkg::NUM_VOICES,
  parameter int PHASE_W    = sine_pkg::PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic               cfg_en,
  output logic [11:0]        mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               overrun
);
  import sine_pkg::*;

  state_t                    state, state_next;
  logic [VIDX_W-1:0]         vidx, vidx_next;
  logic signed [MIX_W-1:0]   acc, contrib;
  logic [TABLE_ADDR_W-1:0]   addr;
  logic [TABLE_DATA_W-1:0]   rom_data;
  logic [PHASE_W-1:0]        phase [NUM_VOICES];
  logic [PHASE_W-1:0]        inc   [NUM_VOICES];
  logic [NUM_VOICES-1:0]     en;
  logic                      start, run, finish, last_voice;

  sine_rom u_rom (
    .addr (addr),
    .data (rom_data)
  );

  // NOTE: state lives in always_ff with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (sample_tick) state_next = ST_RUN;
      ST_RUN:  if (last_voice)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    start      = (state == ST_IDLE) && sample_tick;
    run        = (state == ST_RUN);
    finish     = (state == ST_DONE);
    last_voice = (vidx == VIDX_W'(NUM_VOICES - 1));
    vidx_next  = vidx + 1'b1;
    contrib    = '0;
    if (en[vidx]) contrib = $signed({2'b00, rom_data}) - MIX_W'(TABLE_MID);
  end

  // NOTE: voice registers are flops, not RAM, so they are all reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
      end
      en <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        // A disabling write wins over the scheduled advance; a plain write keeps phase.
        if (cfg_we && cfg_voice == VIDX_W'(i) && !cfg_en)
          phase[i] <= '0;
        else if (run && vidx == VIDX_W'(i) && en[i])
          phase[i] <= phase[i] + inc[i];
      end
      if (cfg_we) begin
        inc[cfg_voice] <= cfg_inc;
        en[cfg_voice]  <= cfg_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vidx      <= '0;
      acc       <= '0;
      addr      <= '0;
      mix_out   <= MIX_W'(MIX_MID);
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= busy && sample_tick;
      if (start) begin
        vidx <= '0;
        acc  <= '0;
        addr <= phase[0][PHASE_W-1 -: TABLE_ADDR_W];
      end else if (run) begin
        acc  <= acc + contrib;
        vidx <= vidx_next;
        addr <= phase[vidx_next][PHASE_W-1 -: TABLE_ADDR_W];
      end else if (finish) begin
        mix_out   <= acc + MIX_W'(MIX_MID);
        mix_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sine_voice_sched.sv
// Directed bench for sine_voice_sched: latency, mixing, overrun, config collisions, reset abort.
module tb_sine_voice_sched;

  logic        clk = 1'b0;
  logic        rst, sample_tick, cfg_we, cfg_en;
  logic [1:0]  cfg_voice;
  logic [23:0] cfg_inc;
  logic [11:0] mix_out;
  logic        mix_valid, busy, overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sine_voice_sched #(.NUM_VOICES(4), .PHASE_W(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_voice   (cfg_voice),
    .cfg_inc     (cfg_inc),
    .cfg_en      (cfg_en),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [23:0] i, input logic e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = v; cfg_inc = i; cfg_en = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One tick; optionally a config write lands on the edge that processes voice 0.
  task automatic run_sample(input string name, input logic [11:0] exp_mix, input bit coll,
                            input logic [1:0] cv, input logic [23:0] ci, input logic ce);
    int lat = 0, busy_n = 0, valid_n = 0, ovr_n = 0;
    logic [11:0] got = '0;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        sample_tick = 1'b0;
        if (coll) begin
          cfg_we = 1'b1; cfg_voice = cv; cfg_inc = ci; cfg_en = ce;
        end
      end
      if (i == 2) cfg_we = 1'b0;
      if (busy) busy_n++;
      if (overrun) ovr_n++;
      if (mix_valid) begin
        valid_n++;
        if (lat == 0) begin lat = i; got = mix_out; end
      end
    end
    total++; if (lat !== 6) begin bad++; $display("FAIL %s latency: got %0d want 6", name, lat); end
    total++; if (got !== exp_mix) begin bad++; $display("FAIL %s mix_out: got %0d want %0d", name, got, exp_mix); end
    total++; if (busy_n !== 5) begin bad++; $display("FAIL %s busy cycles: got %0d want 5", name, busy_n); end
    total++; if (valid_n !== 1) begin bad++; $display("FAIL %s valid pulses: got %0d want 1", name, valid_n); end
    total++; if (ovr_n !== 0) begin bad++; $display("FAIL %s overrun pulses: got %0d want 0", name, ovr_n); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (mix_out !== 12'd2048) begin bad++; $display("FAIL reset mix_out: got %0d want 2048", mix_out); end
    total++; if ({mix_valid, busy, overrun} !== 3'b000) begin
      bad++; $display("FAIL reset flags: got %b want 000", {mix_valid, busy, overrun});
    end
    run_sample("no_config", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
  endtask

  task automatic test_single_voice();
    do_reset();
    cfg_write(2'd0, 24'h010000, 1'b1);
    run_sample("v0_addr0", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("v0_addr1", 12'd2061, 1'b0, 2'd0, 24'd0, 1'b0);
  endtask

  task automatic test_all_voices();
    do_reset();
    for (int v = 0; v < 4; v++) cfg_write(2'(v), 24'h400000, 1'b1);
    run_sample("all_q0", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("all_q1", 12'd4092, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("all_q2", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("all_q3", 12'd4,    1'b0, 2'd0, 24'd0, 1'b0);
  endtask

  task automatic test_overrun();
    int ovr_n = 0, ovr_at = 0, valid_n = 0, v1_at = 0, v2_at = 0;
    logic [11:0] m2 = '0;
    do_reset();
    cfg_write(2'd0, 24'h400000, 1'b1);
    @(negedge clk);
    sample_tick = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (overrun) begin ovr_n++; if (ovr_at == 0) ovr_at = i; end
      sample_tick = 1'b0;
      if (i == 2) sample_tick = 1'b1;
      if (mix_valid) begin
        valid_n++;
        if (v1_at == 0) begin v1_at = i; sample_tick = 1'b1; end
        else if (v2_at == 0) begin v2_at = i; m2 = mix_out; end
      end
    end
    total++; if (ovr_n !== 1) begin bad++; $display("FAIL ovr pulses: got %0d want 1", ovr_n); end
    total++; if (ovr_at !== 3) begin bad++; $display("FAIL ovr timing: got %0d want 3", ovr_at); end
    total++; if (v1_at !== 6) begin bad++; $display("FAIL ovr first valid: got %0d want 6", v1_at); end
    total++; if (v2_at !== 12) begin bad++; $display("FAIL ovr retick valid: got %0d want 12", v2_at); end
    total++; if (valid_n !== 2) begin bad++; $display("FAIL ovr valid count: got %0d want 2", valid_n); end
    total++; if (m2 !== 12'd2559) begin bad++; $display("FAIL ovr retick mix: got %0d want 2559", m2); end
  endtask

  task automatic test_disable_mid_run();
    do_reset();
    cfg_write(2'd0, 24'h400000, 1'b1);
    run_sample("dis_a", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("dis_collide", 12'd2559, 1'b1, 2'd0, 24'h400000, 1'b0);
    run_sample("dis_excluded", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    cfg_write(2'd0, 24'h400000, 1'b1);
    run_sample("dis_phase0", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("dis_resume", 12'd2559, 1'b0, 2'd0, 24'd0, 1'b0);
  endtask

  task automatic test_old_inc();
    do_reset();
    cfg_write(2'd0, 24'h400000, 1'b1);
    run_sample("inc_a", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("inc_collide", 12'd2559, 1'b1, 2'd0, 24'h800000, 1'b1);
    run_sample("inc_old_used", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int valid_n = 0;
    do_reset();
    cfg_write(2'd0, 24'h400000, 1'b1);
    run_sample("rmr_a", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("rmr_b", 12'd2559, 1'b0, 2'd0, 24'd0, 1'b0);
    @(negedge clk);
    sample_tick = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) sample_tick = 1'b0;
      if (i == 3) begin
        rst = 1'b1;
        cfg_we = 1'b1; cfg_voice = 2'd0; cfg_inc = 24'h400000; cfg_en = 1'b1;
      end
      if (i == 4) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr busy: got %b want 0", busy); end
        total++; if (mix_out !== 12'd2048) begin bad++; $display("FAIL rmr mix_out: got %0d want 2048", mix_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rmr overrun: got %b want 0", overrun); end
        rst = 1'b0;
        cfg_we = 1'b0;
      end
      if (mix_valid) valid_n++;
    end
    total++; if (valid_n !== 0) begin bad++; $display("FAIL rmr valid pulses: got %0d want 0", valid_n); end
    run_sample("rmr_after1", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
    run_sample("rmr_after2", 12'd2048, 1'b0, 2'd0, 24'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0;
    cfg_voice = 2'd0; cfg_inc = 24'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_voice();
    test_all_voices();
    test_overrun();
    test_disable_mid_run();
    test_old_inc();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_voice_sched.md
SINE_VOICE_SCHED -- requirements
Module: sine_voice_sched

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of oscillator voices sharing one sine table; fixed at 4 for this release.
REQ-002 Parameter PHASE_W, default 24, phase accumulator width per voice; table address = phase[PHASE_W-1 -: 8].
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sample_tick  input  1  one-cycle request to compute one output sample.
REQ-006 cfg_we  input  1  configuration write strobe.
REQ-007 cfg_voice  input  2  voice index for the write.
REQ-008 cfg_inc  input  PHASE_W  phase increment for the voice.
REQ-009 cfg_en  input  1  voice enable for the write.
REQ-010 mix_out  output  12  unsigned mixed sample, midpoint 2048, registered.
REQ-011 mix_valid  output  1  one-cycle pulse, mix_out updated.
REQ-012 busy  output  1  high while a sample computation is in progress.
REQ-013 overrun  output  1  one-cycle pulse, sample_tick dropped.

Function
REQ-014 States: IDLE, RUN, DONE; busy SHALL equal (state != IDLE).
REQ-015 IDLE, sample_tick=1 at edge k: state->RUN, voice index 0, acc cleared, table address register loaded from voice 0 phase.
REQ-016 RUN, one voice per cycle at edges k+1..k+4: add (table_data - 512) as signed 12-bit to acc if voice enabled, else add 0; phase[i] <= phase[i] + inc[i] mod 2^PHASE_W if enabled; load address from voice i+1.
REQ-017 After voice NUM_VOICES-1: state->DONE; at edge k+5: mix_out <= acc + 2048, mix_valid=1, state->IDLE.
REQ-018 Latency: mix_valid high exactly 6 cycles after the tick cycle; busy high for 5 cycles.
REQ-019 Sum range -2044..+2044; mix_out range 4..4092; no saturation required, none possible.
REQ-020 sample_tick while busy=1: ignored, overrun pulses next cycle; no state change.
REQ-021 sample_tick in the mix_valid cycle (state IDLE): accepted normally.
REQ-022 cfg write accepted any cycle, takes effect at next edge; a RUN update of the same voice in that cycle uses old inc/en.
REQ-023 cfg write with cfg_en=0: phase[voice] <= 0 (write priority over RUN update); a disabled voice's phase stays 0.
REQ-024 cfg write with cfg_en=1: phase retained, only inc/en updated.
REQ-025 Disabled voices contribute exactly 0; all disabled -> mix_out = 2048.

Reset
REQ-026 rst SHALL force state IDLE, acc 0, all phase/inc 0, all voices disabled, mix_out 2048, mix_valid/busy/overrun 0.
REQ-027 rst during RUN/DONE SHALL abort the computation with no mix_valid; rst has priority over sample_tick and cfg_we.

Structure
REQ-028 Shared package sine_pkg SHALL hold NUM_VOICES, PHASE_W, TABLE_ADDR_W=8, TABLE_DATA_W=10, TABLE_MID=512, MIX_MID=2048, and the state enum.
REQ-029 One sub-module only: sine_rom (8-bit address, 10-bit unsigned combinational data, midpoint 512), driven by a registered address.
REQ-030 Per-voice inc/en/phase stored as register arrays; no RAM inference needed.

Verification
REQ-031 Reset, no config, tick -> mix_valid 6 cycles later, mix_out=2048; overrun=0.
REQ-032 Voice0 inc=0x010000 en=1, ticks 1,2 -> mix_out 2048 then 2061 (table addr 1 = 525).
REQ-033 All voices inc=0x400000 en=1, ticks 1..4 -> mix_out 2048, 4092, 2048, 4 (max/min range).
REQ-034 Tick, second tick 2 cycles later -> one mix_valid only, overrun pulse once; tick in mix_valid cycle -> accepted.
REQ-035 Voice0 disabled via cfg_en=0 mid-RUN -> its phase reads 0 afterward, next sample excludes it; old inc used if write collides with its update.
REQ-036 rst asserted at edge k+3 of a computation -> no mix_valid, mix_out=2048, busy=0 next cycle.
